vplayer: RTL
============

Name: vplayer

Overview:
- Frame playback engine: the read-out counterpart of the capture instrument.
- Software loads a waveform of 18-bit samples into an internal 2^ADDR_WIDTH-deep memory over a same-clock write port.
- On run plus trigger, the block streams the frame out as dv_out/d_out, pacing one sample per enable strobe, with the same run/done handshake as the capture side.
- Output feeds DAC/test-pattern paths or loops back into the capture instrument.

Parameters:
- ADDR_WIDTH, 12, memory address width; depth = 2^ADDR_WIDTH (4096).
- DATA_WIDTH, 18, sample width stored and played.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  sample strobe; while playing, one sample is issued per clk with enable=1.
- run  in  1  level request; start when high, stop/acknowledge when low.
- done  out  1  frame(s) complete; held until run falls.
- busy  out  1  high in ARM, PLAY, FLUSH.
- trig_in  in  1  start trigger, sampled in ARM.
- loop  in  1  1 = repeat frame continuously while run=1.
- frame_len  in  ADDR_WIDTH  samples per frame; 0 means 2^ADDR_WIDTH.
- wr_en  in  1  memory write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  32  write data; [DATA_WIDTH-1:0] stored, upper bits ignored.
- wr_err  out  1  sticky; set by a write attempted while busy; cleared on rising edge of run.
- dv_out  out  1  sample valid pulse.
- d_out  out  DATA_WIDTH  sample; holds last value between dv_out pulses.
- trig_out  out  1  pulse coincident with dv_out of sample 0 of each frame.

Behaviour:
- Reset, async on resetn=0: state=IDLE; done, busy, wr_err, dv_out, trig_out = 0; d_out = 0; read pointer = 0. Memory contents are not cleared.
- Memory: write is synchronous (mem[wr_addr] <= wr_data[DATA_WIDTH-1:0]). Read has 1-cycle latency.
- Writes are accepted only in IDLE and DONE. A write in ARM/PLAY/FLUSH is dropped and sets wr_err.
- States:
  - IDLE: ptr=0. run=1 -> ARM.
  - ARM: busy=1. run=0 -> IDLE (abort, no done). trig_in=1 -> PLAY in the next cycle, ptr=0.
  - PLAY: each cycle with enable=1, read mem[ptr] and increment ptr. On the read of ptr = frame_len-1 (wrap-aware):
    - loop=1 and run=1: ptr<=0, stay in PLAY.
    - otherwise: -> FLUSH.
  - run falling mid-frame does not truncate the frame; the current frame always completes.
  - FLUSH: 1 cycle, lets the final dv_out emerge. -> DONE.
  - DONE: done=1, busy=0. run=0 -> IDLE. If run is still 0 on entry, exit on the next cycle.
  - Undefined state encodings -> IDLE.
- Output timing: dv_out is asserted exactly 1 clk after each issuing (enable=1) PLAY cycle, with d_out = the addressed sample. trig_out=1 on the dv_out for ptr=0.
- Latencies:
  - First dv_out occurs no earlier than 2 clks after the trigger cycle: ARM->PLAY edge, then read latency.
  - With enable tied high, a frame of N samples produces N consecutive dv_out cycles.
- Pointer arithmetic is ADDR_WIDTH-bit modulo. frame_len=0 compares end at ptr = 2^ADDR_WIDTH-1.
- Simultaneous events:
  - trig_in in IDLE is ignored; only ARM samples it.
  - trig_in during PLAY is ignored (no retrigger).
  - A run rising edge coinciding with a wr_err-setting write: the clear wins.
  - enable=0 in PLAY stalls ptr; dv_out stays 0.
- wr_err clears on the run 0->1 edge (registered run compare).

Test Plan:
- Load mem[0..7] = 0,1,...,7; frame_len=8; enable=1; run=1; trig_in pulse at cycle T -> dv_out high in cycles T+2..T+9, d_out=0..7, trig_out only at T+2; done=1 at T+11; run=0 -> done=0 next cycle.
- enable toggling 1,0,1,0 with frame_len=4, data 0x3FFFF,0x20000,0x1FFFF,0 -> 4 dv_out pulses spaced 2 clks with exactly those values; d_out holds between pulses.
- frame_len=0, enable=1 -> 4096 dv_out pulses; last d_out = mem[4095]; ptr wraps to 0; one trig_out.
- loop=1, frame_len=3, run held for 10 samples then dropped -> d_out sequence 0,1,2,0,1,2,0,1,2,0,1,2 (frame finishes); trig_out on each 0; then done.
- Write during PLAY -> memory unchanged (readback via later playback); wr_err=1; next run rise -> wr_err=0. run=0 while in ARM -> IDLE, no done.
- resetn low mid-PLAY -> all outputs 0 asynchronously. After release, replay without reloading -> same data as pre-reset (memory preserved).

Source files
------------

// File: rtl/vplayer.sv
// vplayer: frame playback engine streaming a loaded 2^ADDR_WIDTH-deep sample memory
// out one sample per enable strobe, with the run/done handshake of the capture side.
module vplayer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  run,
  output logic                  done,
  output logic                  busy,
  input  logic                  trig_in,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] frame_len,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  output logic                  wr_err,
  output logic                  dv_out,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  trig_out
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  done_q, done_d, wr_err_q, wr_err_d, dv_q, trig_q, run_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                  issue, last;
  assign issue = state_q == S_PLAY && enable;
  // frame_len of 0 wraps to all-ones, giving a full-depth frame
  assign last  = ptr_q == frame_len - ADDR_WIDTH'(1);
  assign busy  = state_q == S_ARM || state_q == S_PLAY || state_q == S_FLUSH;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        ptr_d   = '0;
        state_d = run ? S_ARM : S_IDLE;
      end
      S_ARM: begin
        ptr_d   = '0;
        state_d = !run ? S_IDLE : trig_in ? S_PLAY : S_ARM;
      end
      S_PLAY: if (issue) begin
        ptr_d   = last ? '0 : ptr_q + ADDR_WIDTH'(1);
        state_d = last && !(loop && run) ? S_FLUSH : S_PLAY;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = run ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // done shows for at least one cycle even if run was already low on entry
  assign done_d   = state_q == S_DONE && !(done_q && !run);
  assign wr_err_d = run && !run_q ? 1'b0 : wr_en && busy ? 1'b1 : wr_err_q;
  always_ff @(posedge clk)
    if (wr_en && !busy) mem[wr_addr] <= wr_data[DATA_WIDTH-1:0];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      dv_q     <= 1'b0;
      trig_q   <= 1'b0;
      run_q    <= 1'b0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      dv_q     <= issue;
      trig_q   <= issue && ptr_q == '0;
      run_q    <= run;
      d_q      <= issue ? mem[ptr_q] : d_q;
    end
  assign done     = done_q;
  assign wr_err   = wr_err_q;
  assign dv_out   = dv_q;
  assign trig_out = trig_q;
  assign d_out    = d_q;
endmodule
